ws2812_ram_streamer: RTL and testbench
======================================

// Module: ws2812_ram_streamer
// PURPOSE
//  Reader side of ws2812_on_chip_ram. On a start pulse, reads 3*LED_COUNT pixel bytes in
//  address order and serialises each byte MSB first onto the WS2812 data line, then holds
//  the line low for the latch/reset time. Bytes are streamed as stored: G,R,B per LED,
//  LED 0 at address 0. Sits between the pixel RAM and the board's LED data pin; clk = 10 MHz.
// PARAMETERS
//  LED_COUNT   8    LEDs in the chain; frame length = 3*LED_COUNT bytes (must be >= 1)
//  ADDR_WIDTH  8    RAM address width; 3*LED_COUNT <= 2**ADDR_WIDTH
//  T0H         4    high cycles for a '0' bit (400 ns)
//  T1H         8    high cycles for a '1' bit (800 ns)
//  TBIT        12   total cycles per bit (1.2 us); T0H < T1H < TBIT
//  TRESET      600  low cycles after last bit (60 us, >= 50 us latch)
// PORTS
//  clk       in   1           system clock
//  rst       in   1           synchronous reset, active high
//  start     in   1           1-cycle request to send one frame
//  ram_addr  out  ADDR_WIDTH  byte address presented to the RAM
//  ram_data  in   8           RAM read data, valid 1 cycle after ram_addr (synchronous read)
//  dout      out  1           WS2812 serial data line
//  busy      out  1           high from the cycle after accepted start until done
//  done      out  1           1-cycle pulse when the frame incl. reset gap has completed
// BEHAVIOUR
//  Reset: dout=0, ram_addr=0, busy=0, done=0, FSM=IDLE, all counters 0. A rst asserted
//  mid-frame aborts: next cycle dout=0, busy=0, done stays 0 (no pulse for aborted frame).
//  FSM:
//   IDLE    : start=1 -> PRELOAD, ram_addr<=0, busy<=1. start while busy is ignored.
//   PRELOAD : 2 cycles: cycle 1 wait RAM latency; cycle 2 capture ram_data into shift reg,
//             ram_addr<=1 -> SEND. First dout rise 3 cycles after start sampled high.
//   SEND    : bit counter 0..TBIT-1; dout=1 while counter < (bit ? T1H : T0H), else 0.
//             Bit value = shreg[7]; shift left at end of each bit, 8 bits per byte.
//             Prefetch: ram_addr holds next byte index for the whole byte; in the last
//             cycle of bit 7 next byte is loaded from ram_data and ram_addr increments.
//             No gap between bytes or LEDs: bit period is exactly TBIT everywhere.
//             After bit 7 of byte 3*LED_COUNT-1 -> LATCH (no extra fetch used).
//   LATCH   : dout=0 for TRESET cycles; final cycle pulses done=1, busy<=0 -> IDLE.
//  ram_addr stops at 3*LED_COUNT (one past last byte, data ignored); returns to 0 in IDLE.
//  Counters sized by $clog2 of their limits; no wrap-around inside a frame.
//  start in the same cycle done pulses is ignored; a new start in IDLE the next cycle
//  is accepted. RAM writes during a frame affect bytes not yet fetched only.
//  Total frame = 2 + 24*LED_COUNT*TBIT + TRESET cycles from start to done.
// TESTING
//  1 LED_COUNT=1, RAM {00:AB,01:00,02:FF}, pulse start -> dout highs 8,4,8,4,8,4,8,8 cycles
//    per bit (0xAB), then eight 4-cycle highs, then eight 8-cycle highs; every bit 12 cycles.
//  2 Same run -> done pulses exactly 2+288+600=890 cycles after start; busy high throughout,
//    dout low for final 600 cycles; ram_addr sequence 0,1,2,3.
//  3 LED_COUNT=8 all-0x00 -> 192 bits of 4-high/8-low, no gap at byte boundaries
//    (rising edges exactly 12 cycles apart), done at 2+2304+600 cycles.
//  4 Second start pulsed mid-frame -> ignored; exactly one done; frame identical to case 3.
//  5 rst asserted during byte 1 bit 3 -> next cycle dout=0, busy=0, ram_addr=0; no done;
//    fresh start afterwards streams full frame from address 0.
//  6 start held high across done -> done pulse, then new frame starts; busy low for 1 cycle.

Source files
------------

// File: rtl/ws2812_ram_streamer.sv
// Streams 3*LED_COUNT pixel bytes from a synchronous-read RAM onto a WS2812 data line,
// MSB first, followed by a low latch gap. Outputs are decoded from registered state.
module ws2812_ram_streamer #(
   parameter int unsigned LED_COUNT  = 8,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned T0H        = 4,
   parameter int unsigned T1H        = 8,
   parameter int unsigned TBIT       = 12,
   parameter int unsigned TRESET     = 600
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   input  logic [7:0]            ram_data,
   output logic                  dout,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned BYTES  = 3 * LED_COUNT;
   localparam int unsigned BIT_W  = $clog2(TBIT);
   localparam int unsigned BYTE_W = $clog2(BYTES);
   localparam int unsigned LAT_W  = $clog2(TRESET + 1);

   typedef enum logic [1:0] {IDLE, PRELOAD, SEND, LATCH} state_t;

   state_t                  state, state_n;
   logic [BIT_W-1:0]        bit_cnt, bit_cnt_n;
   logic [2:0]              bit_idx, bit_idx_n;
   logic [BYTE_W-1:0]       byte_cnt, byte_cnt_n;
   logic [LAT_W-1:0]        lat_cnt, lat_cnt_n;
   logic [7:0]              shreg, shreg_n;
   logic [ADDR_WIDTH-1:0]   ram_addr_n;
   logic [BIT_W-1:0]        high_len;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         bit_idx  <= '0;
         byte_cnt <= '0;
         lat_cnt  <= '0;
         shreg    <= '0;
         ram_addr <= '0;
      end else begin
         state    <= state_n;
         bit_cnt  <= bit_cnt_n;
         bit_idx  <= bit_idx_n;
         byte_cnt <= byte_cnt_n;
         lat_cnt  <= lat_cnt_n;
         shreg    <= shreg_n;
         ram_addr <= ram_addr_n;
      end
   end

   assign high_len = shreg[7] ? BIT_W'(T1H) : BIT_W'(T0H);
   assign busy     = (state != IDLE);

   always_comb begin
      state_n    = state;
      bit_cnt_n  = bit_cnt;
      bit_idx_n  = bit_idx;
      byte_cnt_n = byte_cnt;
      lat_cnt_n  = lat_cnt;
      shreg_n    = shreg;
      ram_addr_n = ram_addr;
      dout       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            ram_addr_n = '0;
            bit_cnt_n  = '0;
            bit_idx_n  = '0;
            byte_cnt_n = '0;
            lat_cnt_n  = '0;
            if (start) state_n = PRELOAD;
         end
         PRELOAD: begin
            // bit_cnt doubles as the RAM latency counter here
            if (bit_cnt == '0) begin
               bit_cnt_n = BIT_W'(1);
            end else begin
               shreg_n    = ram_data;
               ram_addr_n = ram_addr + ADDR_WIDTH'(1);
               bit_cnt_n  = '0;
               state_n    = SEND;
            end
         end
         SEND: begin
            dout = (bit_cnt < high_len);
            if (bit_cnt == BIT_W'(TBIT - 1)) begin
               bit_cnt_n = '0;
               if (bit_idx == 3'd7) begin
                  bit_idx_n = '0;
                  if (byte_cnt == BYTE_W'(BYTES - 1)) begin
                     state_n = LATCH;
                  end else begin
                     // ram_addr has been stable all byte, so ram_data is the next byte
                     shreg_n    = ram_data;
                     ram_addr_n = ram_addr + ADDR_WIDTH'(1);
                     byte_cnt_n = byte_cnt + BYTE_W'(1);
                  end
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
                  shreg_n   = {shreg[6:0], 1'b0};
               end
            end else begin
               bit_cnt_n = bit_cnt + BIT_W'(1);
            end
         end
         LATCH: begin
            if (lat_cnt == LAT_W'(TRESET - 1)) begin
               done       = 1'b1;
               state_n    = IDLE;
               ram_addr_n = '0;
               lat_cnt_n  = '0;
            end else begin
               lat_cnt_n = lat_cnt + LAT_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ws2812_ram_streamer.sv
// Bench for ws2812_ram_streamer: a 1-LED and an 8-LED instance, each with its own RAM,
// checked against a per-cycle waveform model derived from the bit timing rules.
module tb_ws2812_ram_streamer;

   localparam int unsigned T0H    = 4;
   localparam int unsigned T1H    = 8;
   localparam int unsigned TBIT   = 12;
   localparam int unsigned TRESET = 600;

   logic            clk = 1'b0;
   logic            rst;
   logic [1:0]      start_s;
   logic [1:0][7:0] addr_s;
   logic [1:0][7:0] rdata_s;
   logic [1:0]      dout_s;
   logic [1:0]      busy_s;
   logic [1:0]      done_s;
   logic [7:0]      mem [2][256];

   int n_cmp  = 0;
   int n_fail = 0;

   int last_hi;
   int last_rises;
   int widths[$];

   typedef struct {
      logic [7:0]  d0;
      logic [7:0]  d1;
      logic [7:0]  d2;
      int          hi_total;
   } vec_t;

   always #50 clk = ~clk;

   always @(posedge clk) begin
      rdata_s[0] <= mem[0][addr_s[0]];
      rdata_s[1] <= mem[1][addr_s[1]];
   end

   ws2812_ram_streamer #(
      .LED_COUNT(1), .ADDR_WIDTH(8), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET)
   ) dut_a (
      .clk(clk), .rst(rst), .start(start_s[0]), .ram_addr(addr_s[0]),
      .ram_data(rdata_s[0]), .dout(dout_s[0]), .busy(busy_s[0]), .done(done_s[0])
   );

   ws2812_ram_streamer #(
      .LED_COUNT(8), .ADDR_WIDTH(8), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET)
   ) dut_b (
      .clk(clk), .rst(rst), .start(start_s[1]), .ram_addr(addr_s[1]),
      .ram_data(rdata_s[1]), .dout(dout_s[1]), .busy(busy_s[1]), .done(done_s[1])
   );

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int nbytes_of(input int u);
      return (u == 0) ? 3 : 24;
   endfunction

   // Expected dout in cycle k after the start edge (k=1 is the first cycle after it)
   function automatic logic model_dout(input int u, input int k);
      int         n_cyc;
      int         t;
      int         bn;
      int         ph;
      logic [7:0] by;
      logic       b;
      n_cyc = nbytes_of(u) * 8 * TBIT;
      if (k < 3 || k > 2 + n_cyc) return 1'b0;
      t  = k - 3;
      bn = t / TBIT;
      ph = t % TBIT;
      by = mem[u][bn / 8];
      b  = by[7 - (bn % 8)];
      return (ph < (b ? T1H : T0H));
   endfunction

   task automatic run_frame(input int u, input bit hold, input bit mid);
      int         nb;
      int         f_len;
      int         dmis;
      int         bmis;
      int         done_cnt;
      int         done_at;
      int         amis;
      int         imis;
      int         run;
      logic       d;
      logic       prevd;
      logic [7:0] aq[$];
      int         rises[$];
      nb       = nbytes_of(u);
      f_len    = 2 + nb * 8 * TBIT + TRESET;
      dmis     = 0;
      bmis     = 0;
      done_cnt = 0;
      done_at  = -1;
      amis     = 0;
      imis     = 0;
      run      = 0;
      prevd    = 1'b0;
      last_hi  = 0;
      widths.delete();
      start_s[u] = 1'b1;
      for (int k = 1; k <= f_len + 1; k++) begin
         @(negedge clk);
         if (k == 1 && !hold) start_s[u] = 1'b0;
         if (mid && k == f_len / 2)     start_s[u] = 1'b1;
         if (mid && k == f_len / 2 + 1) start_s[u] = 1'b0;
         d = dout_s[u];
         if (k <= f_len && d !== model_dout(u, k)) dmis++;
         if (k > f_len && d !== 1'b0) dmis++;
         if (busy_s[u] !== (k <= f_len)) bmis++;
         if (done_s[u] === 1'b1) begin
            done_cnt++;
            done_at = k;
         end
         if (k <= f_len && (aq.size() == 0 || aq[$] != addr_s[u])) aq.push_back(addr_s[u]);
         if (d && !prevd) rises.push_back(k);
         if (d) begin
            last_hi++;
            run++;
         end else if (run > 0) begin
            widths.push_back(run);
            run = 0;
         end
         prevd = d;
      end
      for (int i = 0; i < aq.size(); i++) if (aq[i] != 8'(i)) amis++;
      for (int i = 1; i < rises.size(); i++) if (rises[i] - rises[i-1] != TBIT) imis++;
      last_rises = rises.size();
      check("dout_wave_mismatch_cycles", dmis, 0);
      check("busy_wave_mismatch_cycles", bmis, 0);
      check("done_pulse_count", done_cnt, 1);
      check("done_cycle_after_start", done_at, f_len);
      check("ram_addr_seq_len", aq.size(), nb + 1);
      check("ram_addr_seq_mismatch", amis, 0);
      check("rise_interval_mismatch", imis, 0);
      check("rise_count", last_rises, nb * 8);
   endtask

   initial begin
      vec_t tbl[4];
      int   exp_w[8];
      int   wmis;
      int   dcnt;
      int   f_len;

      tbl[0] = '{d0: 8'hAB, d1: 8'h00, d2: 8'hFF, hi_total: 148};
      tbl[1] = '{d0: 8'h00, d1: 8'h00, d2: 8'h00, hi_total: 96};
      tbl[2] = '{d0: 8'hFF, d1: 8'hFF, d2: 8'hFF, hi_total: 192};
      tbl[3] = '{d0: 8'h80, d1: 8'h01, d2: 8'h55, hi_total: 120};
      exp_w  = '{8, 4, 8, 4, 8, 4, 8, 8};

      for (int u = 0; u < 2; u++) for (int a = 0; a < 256; a++) mem[u][a] = 8'h00;
      rst     = 1'b1;
      start_s = '0;
      repeat (3) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         check("reset_dout", dout_s[u], 0);
         check("reset_busy", busy_s[u], 0);
         check("reset_done", done_s[u], 0);
         check("reset_ram_addr", addr_s[u], 0);
      end
      rst = 1'b0;
      @(negedge clk);

      foreach (tbl[i]) begin
         mem[0][0] = tbl[i].d0;
         mem[0][1] = tbl[i].d1;
         mem[0][2] = tbl[i].d2;
         run_frame(0, 1'b0, 1'b0);
         check("table_high_cycles", last_hi, tbl[i].hi_total);
         check("table_rises", last_rises, 24);
         if (i == 0) begin
            wmis = 0;
            for (int b = 0; b < 8; b++) check("byte0_bit_width", widths[b], exp_w[b]);
            for (int b = 8; b < 16; b++)  if (widths[b] != 4) wmis++;
            for (int b = 16; b < 24; b++) if (widths[b] != 8) wmis++;
            check("byte1_2_width_mismatch", wmis, 0);
         end
         @(negedge clk);
      end

      for (int r = 0; r < 4; r++) begin
         for (int a = 0; a < 3; a++) mem[0][a] = 8'($urandom);
         run_frame(0, 1'b0, 1'b0);
      end
      for (int r = 0; r < 2; r++) begin
         for (int a = 0; a < 24; a++) mem[1][a] = 8'($urandom);
         run_frame(1, 1'b0, 1'b0);
      end

      // all-zero 8-LED frame, then the same with a start pulse mid-frame
      for (int a = 0; a < 24; a++) mem[1][a] = 8'h00;
      run_frame(1, 1'b0, 1'b0);
      check("zero_frame_high_cycles", last_hi, 192 * 4);
      run_frame(1, 1'b0, 1'b1);
      check("mid_start_high_cycles", last_hi, 192 * 4);

      // abort with rst during byte 1, bit 3
      mem[0][0] = 8'h5A; mem[0][1] = 8'hC3; mem[0][2] = 8'h0F;
      start_s[0] = 1'b1;
      for (int k = 1; k <= 140; k++) begin
         @(negedge clk);
         if (k == 1) start_s[0] = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      check("abort_dout", dout_s[0], 0);
      check("abort_busy", busy_s[0], 0);
      check("abort_ram_addr", addr_s[0], 0);
      check("abort_done", done_s[0], 0);
      rst  = 1'b0;
      dcnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (done_s[0] === 1'b1) dcnt++;
      end
      check("abort_no_done", dcnt, 0);
      run_frame(0, 1'b0, 1'b0);

      // start held high across done: ignored in the done cycle, accepted the next
      @(negedge clk);
      run_frame(0, 1'b1, 1'b0);
      @(negedge clk);
      check("restart_busy", busy_s[0], 1);
      start_s[0] = 1'b0;
      f_len = 2 + 24 * TBIT + TRESET;
      dcnt  = 0;
      for (int k = 2; k <= f_len + 1; k++) begin
         @(negedge clk);
         if (done_s[0] === 1'b1) begin
            dcnt++;
            check("restart_done_cycle", k, f_len);
         end
      end
      check("restart_done_count", dcnt, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
